read_hazard_ctrl: RTL and testbench

//  Scoreboard and stall controller for the register-read stage. Tracks in-flight writes to

---
 rtl/read_hazard_if.sv | 21 ++
 rtl/read_hazard_ctrl.sv | 76 +++++++
 tb/tb_read_hazard_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/read_hazard_if.sv
// read_hazard_if: read-stage / writeback handshake bundle for the hazard controller
interface read_hazard_if;
  logic        id_v;
  logic [31:0] id_ir;
  logic        id_fire;
  logic        wb_v;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        stall;
  logic [31:0] pending_mask;
  logic [2:0]  inflight;
  logic        err;
  modport master (
    output id_v, id_ir, id_fire, wb_v, wb_addr, flush,
    input  stall, pending_mask, inflight, err
  );
  modport slave (
    input  id_v, id_ir, id_fire, wb_v, wb_addr, flush,
    output stall, pending_mask, inflight, err
  );
endinterface

// File: rtl/read_hazard_ctrl.sv
// read_hazard_ctrl: per-register write scoreboard and read-stage stall/throttle control
module read_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 2
) (
  input logic         clk,
  input logic         rst_n,
  read_hazard_if.slave bus
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [2:0]       IMAX = 3'(MAX_INFLIGHT);
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [2:0]       inflight_q, inflight_d;
  logic             err_q, err_d;
  logic [6:0]       op;
  logic [4:0]       rs1, rs2, rd;
  logic             known, rs1_used, rs2_used, rd_wr;
  logic [CNT_W-1:0] wb_cnt;
  logic             ret, wb_bad, iss, same, haz1, haz2, stall_c, up, down;
  logic             unused_ir;
  assign op        = bus.id_ir[6:0];
  assign rd        = bus.id_ir[11:7];
  assign rs1       = bus.id_ir[19:15];
  assign rs2       = bus.id_ir[24:20];
  assign unused_ir = ^{bus.id_ir[31:25], bus.id_ir[14:12]};
  assign known     = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                                7'b1110011};
  assign rs1_used  = known && !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign rs2_used  = op inside {7'b1100011, 7'b0100011, 7'b0110011};
  assign rd_wr     = known && !(op inside {7'b1100011, 7'b0100011}) && rd != 5'd0;
  assign wb_cnt    = cnt_q[bus.wb_addr];
  assign ret       = bus.wb_v && bus.wb_addr != 5'd0 && wb_cnt != '0;
  assign wb_bad    = bus.wb_v && bus.wb_addr != 5'd0 && wb_cnt == '0;
  // a source is still hazardous only if same-cycle writeback does not cover its last pending write
  assign haz1      = rs1 != 5'd0 && ((bus.wb_v && bus.wb_addr == rs1) ? cnt_q[rs1] > CNT_W'(1) : cnt_q[rs1] != '0);
  assign haz2      = rs2 != 5'd0 && ((bus.wb_v && bus.wb_addr == rs2) ? cnt_q[rs2] > CNT_W'(1) : cnt_q[rs2] != '0);
  assign stall_c   = bus.id_v && !bus.flush && ((rs1_used && haz1) || (rs2_used && haz2) ||
                     (rd_wr && cnt_q[rd] == CMAX) ||
                     (rd_wr && inflight_q == IMAX && !(bus.wb_v && wb_cnt != '0)));
  assign iss       = bus.id_fire && rd_wr;
  assign same      = iss && ret && rd == bus.wb_addr;
  assign up        = iss && !same && cnt_q[rd] != CMAX && inflight_q != 3'd7;
  assign down      = ret && !same && inflight_q != 3'd0;
  assign bus.stall    = stall_c;
  assign bus.inflight = inflight_q;
  assign bus.err      = err_q;
  // pending view of the scoreboard
  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < 32; i++) bus.pending_mask[i] = cnt_q[i] != '0;
  end
  // next scoreboard state: flush clears, issue/retire to the same register cancel
  always_comb begin
    cnt_d = cnt_q;
    if (bus.flush) cnt_d = '{default: '0};
    else if (!same) begin
      if (iss && cnt_q[rd] != CMAX) cnt_d[rd] = cnt_q[rd] + 1'b1;
      if (ret) cnt_d[bus.wb_addr] = wb_cnt - 1'b1;
    end
    inflight_d = bus.flush ? 3'd0 : inflight_q + {2'b0, up} - {2'b0, down};
    err_d      = err_q | (!bus.flush && (wb_bad || (bus.id_fire && stall_c)));
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q      <= '{default: '0};
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
endmodule

// File: tb/tb_read_hazard_ctrl.sv
// tb_read_hazard_ctrl: directed-vector bench for read_hazard_ctrl
module tb_read_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  read_hazard_if bus ();
  read_hazard_ctrl #(.MAX_INFLIGHT(4), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] load(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  task automatic drive(input logic v, input logic [31:0] ir, input logic fire,
                       input logic wv, input logic [4:0] wa, input logic fl);
    bus.id_v = v; bus.id_ir = ir; bus.id_fire = fire;
    bus.wb_v = wv; bus.wb_addr = wa; bus.flush = fl;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    tick; tick;
    rst_n = 1'b1;
    #1;
    chk("rst_pending", bus.pending_mask, 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    tick;
    // load-use
    drive(1, load(5, 1), 1, 0, 0, 0); #1;
    chk("lu_issue_stall", 32'(bus.stall), 0);
    tick;
    chk("lu_pending", bus.pending_mask, 32'h20);
    chk("lu_inflight", 32'(bus.inflight), 1);
    drive(1, add(6, 5, 1), 0, 0, 0, 0); #1;
    chk("lu_stall1", 32'(bus.stall), 1);
    tick;
    chk("lu_stall2", 32'(bus.stall), 1);
    drive(1, add(6, 5, 1), 0, 1, 5, 0); #1;
    chk("lu_fwd_stall", 32'(bus.stall), 0);
    drive(1, add(6, 5, 1), 1, 1, 5, 0);
    tick;
    chk("lu_pending_after", bus.pending_mask, 32'h40);
    chk("lu_inflight_after", 32'(bus.inflight), 1);
    drive(0, 0, 0, 1, 6, 0);
    tick;
    chk("lu_drain_pending", bus.pending_mask, 0);
    chk("lu_drain_inflight", 32'(bus.inflight), 0);
    chk("lu_err", 32'(bus.err), 0);
    // throttle
    for (int i = 1; i <= 4; i++) begin
      drive(1, addi(5'(i), 0), 1, 0, 0, 0); #1;
      chk("thr_issue_stall", 32'(bus.stall), 0);
      tick;
    end
    chk("thr_inflight4", 32'(bus.inflight), 4);
    chk("thr_pending4", bus.pending_mask, 32'h1E);
    drive(1, addi(8, 0), 0, 0, 0, 0); #1;
    chk("thr_stall5", 32'(bus.stall), 1);
    drive(1, addi(8, 0), 0, 1, 2, 0); #1;
    chk("thr_stall_wb", 32'(bus.stall), 0);
    drive(1, addi(8, 0), 1, 1, 2, 0);
    tick;
    chk("thr_inflight_keep", 32'(bus.inflight), 4);
    chk("thr_pending_swap", bus.pending_mask, 32'h11A);
    drive(0, 0, 0, 1, 1, 0); tick;
    drive(0, 0, 0, 1, 3, 0); tick;
    chk("thr_drain_inflight", 32'(bus.inflight), 2);
    drive(1, addi(7, 0), 1, 0, 0, 0); tick;
    chk("sr_pre_pending", bus.pending_mask, 32'h190);
    // same-register issue and retire
    drive(1, addi(7, 0), 1, 1, 7, 0); #1;
    chk("sr_stall", 32'(bus.stall), 0);
    tick;
    chk("sr_pending", bus.pending_mask, 32'h190);
    chk("sr_inflight", 32'(bus.inflight), 3);
    chk("sr_err", 32'(bus.err), 0);
    // flush with concurrent issue and writeback
    drive(1, addi(9, 0), 1, 1, 4, 1); #1;
    chk("fl_stall_during", 32'(bus.stall), 0);
    tick;
    chk("fl_pending", bus.pending_mask, 0);
    chk("fl_inflight", 32'(bus.inflight), 0);
    chk("fl_err", 32'(bus.err), 0);
    drive(1, add(6, 4, 7), 0, 0, 0, 0); #1;
    chk("fl_stall_after", 32'(bus.stall), 0);
    // spurious writeback error, sticky
    drive(0, 0, 0, 1, 9, 0); tick;
    chk("err_set", 32'(bus.err), 1);
    chk("err_no_count", 32'(bus.inflight), 0);
    drive(1, addi(3, 0), 1, 0, 0, 0); tick;
    drive(0, 0, 0, 1, 3, 0); tick;
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("err_sticky", 32'(bus.err), 1);
    chk("err_traffic_inflight", 32'(bus.inflight), 0);
    // asynchronous reset mid-run
    drive(1, addi(1, 0), 1, 0, 0, 0); tick;
    drive(1, addi(2, 0), 1, 0, 0, 0); tick;
    chk("ar_inflight_live", 32'(bus.inflight), 2);
    drive(1, add(3, 1, 2), 0, 0, 0, 0); #1;
    chk("ar_stall_live", 32'(bus.stall), 1);
    rst_n = 1'b0; #1;
    chk("ar_pending", bus.pending_mask, 0);
    chk("ar_inflight", 32'(bus.inflight), 0);
    chk("ar_err", 32'(bus.err), 0);
    chk("ar_stall", 32'(bus.stall), 0);
    tick;
    rst_n = 1'b1;
    // writeback to x0 is not an error, x0 never counted
    drive(0, 0, 0, 1, 0, 0); tick;
    chk("x0_wb_err", 32'(bus.err), 0);
    drive(1, addi(0, 0), 1, 0, 0, 0); tick;
    chk("x0_inflight", 32'(bus.inflight), 0);
    chk("x0_pending", bus.pending_mask, 0);
    // per-register saturation
    for (int i = 0; i < 3; i++) begin
      drive(1, addi(10, 0), 1, 0, 0, 0); tick;
    end
    chk("sat_pending", bus.pending_mask, 32'h400);
    chk("sat_inflight", 32'(bus.inflight), 3);
    drive(1, addi(10, 0), 0, 0, 0, 0); #1;
    chk("sat_stall", 32'(bus.stall), 1);
    // fire while stalled is an error but still counted
    drive(1, add(11, 10, 0), 1, 0, 0, 0); #1;
    chk("sf_stall", 32'(bus.stall), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("sf_err", 32'(bus.err), 1);
    chk("sf_pending", bus.pending_mask, 32'hC00);
    chk("sf_inflight", 32'(bus.inflight), 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
